// File: rtl/m68k_bus_ctrl_if.sv
// CPU-side and region-side bus of the 68000 bus controller. The controller is
// the slave of the CPU cycle; whatever drives the CPU pins and region data uses master.
interface m68k_bus_ctrl_if #(
  parameter int N_REGIONS = 8
);
  logic [23:1]             cpu_a;
  logic                    cpu_as_n;
  logic                    cpu_uds_n;
  logic                    cpu_lds_n;
  logic                    cpu_rw;
  logic                    dtack_n;
  logic                    berr_n;
  logic [15:0]             cpu_din;
  logic [N_REGIONS*16-1:0] region_din;
  logic [N_REGIONS-1:0]    sel;
  logic [N_REGIONS-1:0]    wr;

  modport slave (
    input  cpu_a, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, region_din,
    output dtack_n, berr_n, cpu_din, sel, wr
  );

  modport master (
    output cpu_a, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, region_din,
    input  dtack_n, berr_n, cpu_din, sel, wr
  );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: Phi1/Phi2 enables, region decode with wait states,
// DTACK/BERR handshake, read-data mux and a stuck-bus watchdog.
module m68k_bus_ctrl #(
  parameter int                          N_REGIONS     = 8,
  parameter int                          DEC_HI        = 17,
  parameter int                          DEC_LO        = 15,
  parameter int                          PHI_DIV       = 2,
  parameter int                          WAIT_W        = 4,
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAITS  = '0,
  parameter logic [7:0]                  REGION_VALID  = 8'hFF,
  parameter bit                          BERR_UNMAPPED = 1'b1,
  parameter int                          WDOG_CYCLES   = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic           phi1,
  output logic           phi2,
  m68k_bus_ctrl_if.slave bus,
  output logic           wdog_err
);

  localparam int PW  = $clog2(PHI_DIV);
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [PW-1:0]  P_LAST  = PW'(PHI_DIV - 1);
  localparam logic [PW-1:0]  P_HALF  = PW'(PHI_DIV / 2);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_BERR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 phi1_q, phi1_d, phi2_q, phi2_d;
  logic [N_REGIONS-1:0] oh_q, oh_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 armed_q, armed_d;
  logic                 wdog_q, wdog_d;
  logic                 dtack_n_q, dtack_n_d;
  logic                 berr_n_q, berr_n_d;
  logic [15:0]          din_q, din_d;
  logic [N_REGIONS-1:0] sel_q, sel_d;
  logic [N_REGIONS-1:0] wr_q, wr_d;
  logic [N_REGIONS-1:0] addr_oh_s;
  logic [WAIT_W-1:0]    addr_wait_s;
  logic [15:0]          rdata_s;
  logic                 start_s;
  logic                 addr_unused_s;

  // Only the region index bits of the address take part in decoding.
  assign addr_unused_s = ^bus.cpu_a;

  // A cycle starts only after AS has been seen high since the last accepted one.
  assign start_s = armed_q & ~bus.cpu_as_n & (~bus.cpu_uds_n | ~bus.cpu_lds_n);

  // Phase counter and Phi1/Phi2 enables.
  always_comb begin
    p_d    = p_q + PW'(1);
    phi1_d = (p_q == {PW{1'b0}});
    phi2_d = (p_q == P_HALF);
    if (p_q == P_LAST) begin
      p_d = {PW{1'b0}};
    end else begin
      p_d = p_q + PW'(1);
    end
  end

  // Live-address decode; unmapped or out-of-range indexes give an all-zero one-hot.
  always_comb begin
    addr_oh_s   = {N_REGIONS{1'b0}};
    addr_wait_s = {WAIT_W{1'b0}};
    for (int i = 0; i < N_REGIONS; i++) begin
      if ((int'(bus.cpu_a[DEC_HI:DEC_LO]) == i) && REGION_VALID[i]) begin
        addr_oh_s[i] = 1'b1;
        addr_wait_s  = REGION_WAITS[i*WAIT_W +: WAIT_W];
      end else begin
        addr_oh_s[i] = 1'b0;
      end
    end
  end

  // Bus cycle FSM, wait-state counter and watchdog.
  always_comb begin
    state_d = state_q;
    oh_d    = oh_q;
    cnt_d   = cnt_q;
    wd_d    = {WDW{1'b0}};
    wdog_d  = wdog_q;
    if (bus.cpu_as_n) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          armed_d = 1'b0;
          oh_d    = addr_oh_s;
          cnt_d   = addr_wait_s;
          if (|addr_oh_s) begin
            if (addr_wait_s == {WAIT_W{1'b0}}) begin
              state_d = S_ACK;
            end else begin
              state_d = S_WAIT;
            end
          end else if (BERR_UNMAPPED) begin
            state_d = S_BERR;
          end else begin
            state_d = S_ACK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (phi1_q) begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK, S_BERR: begin
        if (bus.cpu_as_n) begin
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          // Stuck cycle: release the bus; armed stays low until AS is seen high.
          state_d = S_IDLE;
          wdog_d  = 1'b1;
        end else begin
          state_d = state_q;
          wd_d    = wd_q + WDW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-data mux over the selected region; no region selected reads as all ones.
  always_comb begin
    rdata_s = 16'h0000;
    for (int i = 0; i < N_REGIONS; i++) begin
      rdata_s = rdata_s | (bus.region_din[i*16 +: 16] & {16{oh_d[i]}});
    end
    if (oh_d == {N_REGIONS{1'b0}}) begin
      rdata_s = 16'hFFFF;
    end else begin
      rdata_s = rdata_s;
    end
  end

  // Bus outputs follow the next state so they change on the same clk as the FSM.
  always_comb begin
    sel_d     = {N_REGIONS{1'b0}};
    wr_d      = {N_REGIONS{1'b0}};
    dtack_n_d = 1'b1;
    berr_n_d  = 1'b1;
    din_d     = 16'hFFFF;
    if ((state_d == S_WAIT) || (state_d == S_ACK)) begin
      sel_d = oh_d;
    end else begin
      sel_d = {N_REGIONS{1'b0}};
    end
    if ((state_q == S_IDLE) && start_s && !bus.cpu_rw) begin
      wr_d = oh_d;
    end else begin
      wr_d = {N_REGIONS{1'b0}};
    end
    if (state_d == S_ACK) begin
      dtack_n_d = 1'b0;
      din_d     = rdata_s;
    end else begin
      dtack_n_d = 1'b1;
      din_d     = 16'hFFFF;
    end
    if (state_d == S_BERR) begin
      berr_n_d = 1'b0;
    end else begin
      berr_n_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      p_q       <= {PW{1'b0}};
      phi1_q    <= 1'b0;
      phi2_q    <= 1'b0;
      oh_q      <= {N_REGIONS{1'b0}};
      cnt_q     <= {WAIT_W{1'b0}};
      wd_q      <= {WDW{1'b0}};
      armed_q   <= 1'b0;
      wdog_q    <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      din_q     <= 16'hFFFF;
      sel_q     <= {N_REGIONS{1'b0}};
      wr_q      <= {N_REGIONS{1'b0}};
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      phi1_q    <= phi1_d;
      phi2_q    <= phi2_d;
      oh_q      <= oh_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      armed_q   <= armed_d;
      wdog_q    <= wdog_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      din_q     <= din_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
    end
  end

  assign phi1        = phi1_q;
  assign phi2        = phi2_q;
  assign wdog_err    = wdog_q;
  assign bus.dtack_n = dtack_n_q;
  assign bus.berr_n  = berr_n_q;
  assign bus.cpu_din = din_q;
  assign bus.sel     = sel_q;
  assign bus.wr      = wr_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: three instances cover the PHI_DIV=4 phase
// pattern, the main decode/wait/BERR/watchdog paths, and DTACK on unmapped regions.
module tb_m68k_bus_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic phi1_p4, phi2_p4, wdog_p4;
  logic phi1_m, phi2_m, wdog_m;
  logic phi1_nb, phi2_nb, wdog_nb;
  int   n_cmp = 0;
  int   n_bad = 0;

  m68k_bus_ctrl_if #(.N_REGIONS(8)) bus_p4 ();
  m68k_bus_ctrl_if #(.N_REGIONS(8)) bus_m ();
  m68k_bus_ctrl_if #(.N_REGIONS(8)) bus_nb ();

  m68k_bus_ctrl #(.PHI_DIV(4)) u_p4 (
    .clk(clk), .reset_n(reset_n), .phi1(phi1_p4), .phi2(phi2_p4),
    .bus(bus_p4.slave), .wdog_err(wdog_p4)
  );

  m68k_bus_ctrl #(
    .PHI_DIV(2), .REGION_WAITS(32'h0000_30F0), .REGION_VALID(8'h7F),
    .BERR_UNMAPPED(1'b1), .WDOG_CYCLES(16)
  ) u_m (
    .clk(clk), .reset_n(reset_n), .phi1(phi1_m), .phi2(phi2_m),
    .bus(bus_m.slave), .wdog_err(wdog_m)
  );

  m68k_bus_ctrl #(
    .PHI_DIV(2), .REGION_VALID(8'h7F), .BERR_UNMAPPED(1'b0)
  ) u_nb (
    .clk(clk), .reset_n(reset_n), .phi1(phi1_nb), .phi2(phi2_nb),
    .bus(bus_nb.slave), .wdog_err(wdog_nb)
  );

  always #5 clk = ~clk;

  function automatic logic [23:1] addr_of(input int r);
    logic [23:1] a;
    a = '0;
    a[17:15] = r[2:0];
    return a;
  endfunction

  task automatic start_m(input int r, input logic rw);
    bus_m.cpu_a     = addr_of(r);
    bus_m.cpu_rw    = rw;
    bus_m.cpu_as_n  = 1'b0;
    bus_m.cpu_uds_n = 1'b0;
    bus_m.cpu_lds_n = 1'b0;
  endtask

  task automatic idle_m();
    bus_m.cpu_as_n  = 1'b1;
    bus_m.cpu_uds_n = 1'b1;
    bus_m.cpu_lds_n = 1'b1;
    bus_m.cpu_rw    = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din, wdog_m, phi1_m, phi2_m, phi1_p4, phi2_p4}
        !== {1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: dtack_n=%b berr_n=%b sel=%h wr=%h din=%h wdog=%b phi=%b%b%b%b expected 1 1 00 00 ffff 0 0000",
               bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din, wdog_m, phi1_m, phi2_m, phi1_p4, phi2_p4);
    end
  endtask

  task automatic test_phase();
    logic [1:0] exp;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp = {(k % 4 == 0), (k % 4 == 2)};
      n_cmp++;
      if ({phi1_p4, phi2_p4} !== exp) begin
        n_bad++;
        $display("FAIL phase_div4 clk %0d: phi1,phi2=%b expected %b", k, {phi1_p4, phi2_p4}, exp);
      end
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    start_m(0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din} !== {1'b0, 1'b1, 8'h01, 8'h00, 16'h1234}) begin
      n_bad++;
      $display("FAIL read_r0: dtack_n=%b berr_n=%b sel=%h wr=%h din=%h expected 0 1 01 00 1234",
               bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din);
    end
    idle_m();
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel} !== {1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL read_release: dtack_n=%b sel=%h expected 1 00", bus_m.dtack_n, bus_m.sel);
    end
  endtask

  task automatic test_back_to_back();
    start_m(0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.cpu_din} !== {1'b0, 16'h1234}) begin
      n_bad++;
      $display("FAIL b2b_first: dtack_n=%b din=%h expected 0 1234", bus_m.dtack_n, bus_m.cpu_din);
    end
    bus_m.cpu_as_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_m.dtack_n !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gap: dtack_n=%b expected 1", bus_m.dtack_n);
    end
    start_m(2, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel, bus_m.cpu_din} !== {1'b0, 8'h04, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL b2b_second: dtack_n=%b sel=%h din=%h expected 0 04 beef", bus_m.dtack_n, bus_m.sel, bus_m.cpu_din);
    end
    idle_m();
    @(negedge clk);
  endtask

  task automatic test_ds_ignore();
    bus_m.cpu_a    = addr_of(0);
    bus_m.cpu_as_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_m.dtack_n, bus_m.berr_n, bus_m.sel} !== {1'b1, 1'b1, 8'h00}) begin
        n_bad++;
        $display("FAIL ds_high_ignored: dtack_n=%b berr_n=%b sel=%h expected 1 1 00", bus_m.dtack_n, bus_m.berr_n, bus_m.sel);
      end
    end
    bus_m.cpu_lds_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.cpu_din} !== {1'b0, 16'h1234}) begin
      n_bad++;
      $display("FAIL ds_low_starts: dtack_n=%b din=%h expected 0 1234", bus_m.dtack_n, bus_m.cpu_din);
    end
    idle_m();
    @(negedge clk);
  endtask

  task automatic test_write_wait();
    int   pulses;
    logic last_p;
    bit   seen;
    start_m(3, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel, bus_m.wr} !== {1'b1, 8'h08, 8'h08}) begin
      n_bad++;
      $display("FAIL write_start: dtack_n=%b sel=%h wr=%h expected 1 08 08", bus_m.dtack_n, bus_m.sel, bus_m.wr);
    end
    pulses = 0;
    last_p = 1'b0;
    seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!seen) begin
        last_p = phi1_m;
        if (phi1_m) pulses++;
        @(negedge clk);
        n_cmp++;
        if (bus_m.dtack_n === 1'b0) begin
          seen = 1'b1;
          if (!(pulses == 3 && last_p)) begin
            n_bad++;
            $display("FAIL write_wait_len: dtack after %0d phi1 pulses (last=%b) expected 3 (last=1)", pulses, last_p);
          end
        end else if ({bus_m.sel, bus_m.wr} !== {8'h08, 8'h00}) begin
          n_bad++;
          $display("FAIL write_waiting: sel=%h wr=%h expected 08 00", bus_m.sel, bus_m.wr);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL write_timeout: dtack_n=%b expected 0 within 20 clk", bus_m.dtack_n);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel, bus_m.wr} !== {1'b0, 8'h08, 8'h00}) begin
      n_bad++;
      $display("FAIL write_hold: dtack_n=%b sel=%h wr=%h expected 0 08 00", bus_m.dtack_n, bus_m.sel, bus_m.wr);
    end
    idle_m();
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel} !== {1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL write_release: dtack_n=%b sel=%h expected 1 00", bus_m.dtack_n, bus_m.sel);
    end
  endtask

  task automatic test_unmapped();
    start_m(7, 1'b1);
    bus_nb.cpu_a     = addr_of(7);
    bus_nb.cpu_rw    = 1'b1;
    bus_nb.cpu_as_n  = 1'b0;
    bus_nb.cpu_uds_n = 1'b0;
    bus_nb.cpu_lds_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.berr_n, bus_m.sel} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL unmapped_berr: dtack_n=%b berr_n=%b sel=%h expected 1 0 00", bus_m.dtack_n, bus_m.berr_n, bus_m.sel);
    end
    n_cmp++;
    if ({bus_nb.dtack_n, bus_nb.berr_n, bus_nb.sel, bus_nb.cpu_din} !== {1'b0, 1'b1, 8'h00, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL unmapped_dtack: dtack_n=%b berr_n=%b sel=%h din=%h expected 0 1 00 ffff",
               bus_nb.dtack_n, bus_nb.berr_n, bus_nb.sel, bus_nb.cpu_din);
    end
    idle_m();
    bus_nb.cpu_as_n  = 1'b1;
    bus_nb.cpu_uds_n = 1'b1;
    bus_nb.cpu_lds_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus_m.berr_n, bus_nb.dtack_n} !== 2'b11) begin
      n_bad++;
      $display("FAIL unmapped_release: berr_n=%b dtack_n=%b expected 1 1", bus_m.berr_n, bus_nb.dtack_n);
    end
  endtask

  task automatic test_watchdog();
    start_m(0, 1'b1);
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, wdog_m} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL wdog_before: dtack_n=%b wdog_err=%b expected 0 0", bus_m.dtack_n, wdog_m);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel, wdog_m} !== {1'b1, 8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL wdog_fire: dtack_n=%b sel=%h wdog_err=%b expected 1 00 1", bus_m.dtack_n, bus_m.sel, wdog_m);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_m.dtack_n, bus_m.sel, wdog_m} !== {1'b1, 8'h00, 1'b1}) begin
        n_bad++;
        $display("FAIL wdog_no_redecode: dtack_n=%b sel=%h wdog_err=%b expected 1 00 1", bus_m.dtack_n, bus_m.sel, wdog_m);
      end
    end
    bus_m.cpu_as_n = 1'b1;
    @(negedge clk);
    bus_m.cpu_as_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.cpu_din, wdog_m} !== {1'b0, 16'h1234, 1'b1}) begin
      n_bad++;
      $display("FAIL wdog_after_toggle: dtack_n=%b din=%h wdog_err=%b expected 0 1234 1", bus_m.dtack_n, bus_m.cpu_din, wdog_m);
    end
    idle_m();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    start_m(1, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.sel} !== {1'b1, 8'h02}) begin
      n_bad++;
      $display("FAIL midrst_waiting: dtack_n=%b sel=%h expected 1 02", bus_m.dtack_n, bus_m.sel);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din, wdog_m, phi1_m, phi2_m}
        !== {1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_async: dtack_n=%b berr_n=%b sel=%h wr=%h din=%h wdog=%b phi=%b%b expected 1 1 00 00 ffff 0 00",
               bus_m.dtack_n, bus_m.berr_n, bus_m.sel, bus_m.wr, bus_m.cpu_din, wdog_m, phi1_m, phi2_m);
    end
    @(negedge clk);
    bus_m.cpu_a = addr_of(0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_m.dtack_n, bus_m.sel} !== {1'b1, 8'h00}) begin
        n_bad++;
        $display("FAIL midrst_as_held: dtack_n=%b sel=%h expected 1 00", bus_m.dtack_n, bus_m.sel);
      end
    end
    bus_m.cpu_as_n = 1'b1;
    @(negedge clk);
    bus_m.cpu_as_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_m.dtack_n, bus_m.cpu_din} !== {1'b0, 16'h1234}) begin
      n_bad++;
      $display("FAIL midrst_new_cycle: dtack_n=%b din=%h expected 0 1234", bus_m.dtack_n, bus_m.cpu_din);
    end
    idle_m();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    bus_p4.cpu_a = '0;  bus_p4.cpu_as_n = 1'b1; bus_p4.cpu_uds_n = 1'b1;
    bus_p4.cpu_lds_n = 1'b1; bus_p4.cpu_rw = 1'b1; bus_p4.region_din = '0;
    bus_m.cpu_a = '0;
    idle_m();
    bus_m.region_din = '0;
    bus_m.region_din[15:0]    = 16'h1234;
    bus_m.region_din[47:32]   = 16'hBEEF;
    bus_m.region_din[127:112] = 16'h7777;
    bus_nb.cpu_a = '0;  bus_nb.cpu_as_n = 1'b1; bus_nb.cpu_uds_n = 1'b1;
    bus_nb.cpu_lds_n = 1'b1; bus_nb.cpu_rw = 1'b1; bus_nb.region_din = '0;
    bus_nb.region_din[127:112] = 16'h5A5A;

    test_reset();
    test_phase();
    test_read();
    test_back_to_back();
    test_ds_ignore();
    test_write_wait();
    test_unmapped();
    test_watchdog();
    test_reset_mid_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
Parametrised 68000 bus controller sitting between the fx68k core and on-chip memories/peripherals. It replaces hard-tied DTACK/BERR and ad-hoc address compares with:
- generated Phi1/Phi2 enables;
- N-region address decode;
- per-region programmable wait states;
- handshaked DTACK/BERR;
- read-data muxing;
- a stuck-bus watchdog.
One instance per CPU, clocked by the CPU clock.

Parameters:
N_REGIONS, 8, number of decoded regions (1..8)
DEC_HI, 17, MSB of cpu address field used as region index
DEC_LO, 15, LSB of region index field; DEC_HI-DEC_LO+1 = log2(N_REGIONS)
PHI_DIV, 2, clk cycles per CPU phase pair; even, >=2
WAIT_W, 4, width of one wait-state count
REGION_WAITS, 0, packed N_REGIONS*WAIT_W; field i = wait states (Phi1 periods) for region i
REGION_VALID, 8'hFF, bit i=1 means region i is mapped
BERR_UNMAPPED, 1, 1: unmapped access gives BERR; 0: DTACK with data 16'hFFFF
WDOG_CYCLES, 1024, clk cycles a terminated cycle may hold AS low before forced release

Ports:
clk  in  1  CPU clock
reset_n  in  1  asynchronous active-low reset
phi1  out  1  Phi1 enable pulse to fx68k
phi2  out  1  Phi2 enable pulse to fx68k
cpu_a  in  23  cpu address [23:1]
cpu_as_n  in  1  address strobe
cpu_uds_n  in  1  upper data strobe
cpu_lds_n  in  1  lower data strobe
cpu_rw  in  1  1=read, 0=write
dtack_n  out  1  data transfer acknowledge
berr_n  out  1  bus error
cpu_din  out  16  read data to CPU
region_din  in  N_REGIONS*16  packed read data, slice i from region i
sel  out  N_REGIONS  one-hot region select, held for whole cycle
wr  out  N_REGIONS  one-hot write strobe (sel & write), one clk wide
wdog_err  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
Reset values (async on reset_n low):
- phi1=0, phi2=0, dtack_n=1, berr_n=1.
- sel=0, wr=0, cpu_din=16'hFFFF, wdog_err=0.
- FSM in IDLE, phase counter=0.

Phase generator:
- Counter p runs 0..PHI_DIV-1, wrapping.
- phi1=1 when p==0; phi2=1 when p==PHI_DIV/2. Both are registered.
- PHI_DIV=2 gives alternating phi1/phi2 every clk.

FSM states: IDLE, WAIT, ACK, BERR.

IDLE:
- Triggers when cpu_as_n==0 and (cpu_uds_n==0 or cpu_lds_n==0).
- On trigger, latch r = cpu_a[DEC_HI:DEC_LO] and rw.
- Mapped r (REGION_VALID[r]=1, r<N_REGIONS):
  - sel[r]=1 on the next clk.
  - Load wait counter from REGION_WAITS[r].
  - Go to ACK if the count is 0, else to WAIT.
  - If write, wr[r]=1 for exactly the first clk of sel.
- Unmapped r:
  - BERR_UNMAPPED=1: go to BERR.
  - BERR_UNMAPPED=0: go to ACK with cpu_din=16'hFFFF.
- AS low with both DS high (e.g. read-modify-write idle) is ignored.

WAIT:
- Counter decrements on each phi1 pulse.
- Enter ACK on the clk the counter reaches 0.

ACK:
- dtack_n=0.
- cpu_din = region_din slice r, registered every clk while in ACK (first valid data coincides with dtack_n=0).
- Stay until cpu_as_n==1, then go to IDLE: dtack_n=1, sel=0 on the following clk.

BERR:
- berr_n=0 and sel=0.
- Release as in ACK.

Watchdog:
- Counter clears in IDLE and counts clk cycles in ACK/BERR.
- At WDOG_CYCLES: force IDLE, dtack_n=1, berr_n=1, sel=0, and set wdog_err=1.
- A new cycle is not accepted until cpu_as_n has been seen high.

Back-to-back cycles:
- IDLE requires cpu_as_n==1 seen for at least one clk after a terminated cycle.
- An unchanged low AS is never re-decoded.

Reset mid-cycle:
- Immediate return to reset values.
- After reset release, an AS already low is treated as new only after it has been observed high.

Wait-count width: REGION_WAITS fields are unsigned; the maximum wait is 2^WAIT_W-1 Phi1 periods.

Test Plan:
1. PHI_DIV=4, release reset: phi1 high at clk 0,4,8; phi2 at 2,6,10; never both high.
2. Read region 0 (waits=0), region_din[15:0]=16'h1234: dtack_n low 1 clk after AS/DS low, cpu_din=16'h1234 same clk; sel=8'h01; dtack_n high 1 clk after AS rises.
3. Write region 3, REGION_WAITS[3]=3, PHI_DIV=2: wr=8'h08 for 1 clk; dtack_n falls after the 3rd phi1 pulse (~6 clk); sel held until AS high.
4. REGION_VALID=8'h7F, access region 7: BERR_UNMAPPED=1 gives berr_n=0, dtack_n=1, sel=0. BERR_UNMAPPED=0 gives dtack_n=0, cpu_din=16'hFFFF.
5. WDOG_CYCLES=16, hold AS low after DTACK: at clk 16 in ACK, dtack_n=1 and wdog_err=1 (sticky). No re-decode until AS toggles high then low.
6. Assert reset_n low during WAIT: outputs return to reset values asynchronously. After release with AS still low, no DTACK until AS goes high then low again.
